ex_mem_stage: RTL and testbench

//  EX/MEM pipeline stage: captures EX results and control behind the ID/EX register and feeds the MEM stage.

---
 rtl/ex_mem_stage_pkg.sv | 20 ++
 rtl/ex_mem_stage_if.sv | 54 +++++
 rtl/ex_mem_stage_slot.sv | 43 ++++
 rtl/ex_mem_stage.sv | 152 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: control-bit layout and
// occupancy encoding of the main/skid slot pair.
package ex_mem_stage_pkg;

  localparam int EXMEM_CTRL_W  = 6;

  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_JUMP     = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> EX/MEM -> MEM handshake bundle plus the redirect outputs back to fetch.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_regwrite;
  logic              in_wb_memtoreg;
  logic              in_m_branch;
  logic              in_m_memread;
  logic              in_m_memwrite;
  logic              in_jump;
  logic              in_zero;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_store_data;
  logic [DATA_W-1:0] in_br_target;
  logic [DATA_W-1:0] in_jmp_target;
  logic [REG_W-1:0]  in_dest_reg;

  logic              out_valid;
  logic              out_ready;
  logic              out_wb_regwrite;
  logic              out_wb_memtoreg;
  logic              out_m_memread;
  logic              out_m_memwrite;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_dest_reg;

  logic              pc_redirect;
  logic [DATA_W-1:0] pc_target;
  logic              flush_upstream;

  // Stage-side view
  modport slave (
    input  in_valid, in_wb_regwrite, in_wb_memtoreg, in_m_branch, in_m_memread,
           in_m_memwrite, in_jump, in_zero, in_alu_result, in_store_data,
           in_br_target, in_jmp_target, in_dest_reg, out_ready,
    output in_ready, out_valid, out_wb_regwrite, out_wb_memtoreg, out_m_memread,
           out_m_memwrite, out_alu_result, out_store_data, out_dest_reg,
           pc_redirect, pc_target, flush_upstream
  );

  // Environment-side view (EX producer + MEM consumer + fetch)
  modport master (
    output in_valid, in_wb_regwrite, in_wb_memtoreg, in_m_branch, in_m_memread,
           in_m_memwrite, in_jump, in_zero, in_alu_result, in_store_data,
           in_br_target, in_jmp_target, in_dest_reg, out_ready,
    input  in_ready, out_valid, out_wb_regwrite, out_wb_memtoreg, out_m_memread,
           out_m_memwrite, out_alu_result, out_store_data, out_dest_reg,
           pc_redirect, pc_target, flush_upstream
  );
endinterface

// File: rtl/ex_mem_stage_slot.sv
// One payload register with load enable and a valid bit that can be cleared.
// Load wins over clear so a slot can be refilled in the cycle it drains.
module ex_mem_slot
  import ex_mem_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a skid slot so MEM stalls never drop work;
// resolves branch/jump from the main slot and raises the PC redirect.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  ex_mem_stage_if.slave bus
);
  typedef struct packed {
    logic [EXMEM_CTRL_W-1:0] ctrl;
    logic                    zero;
    logic [DATA_W-1:0]       alu;
    logic [DATA_W-1:0]       sd;
    logic [DATA_W-1:0]       bt;
    logic [DATA_W-1:0]       jt;
    logic [REG_W-1:0]        dst;
  } pay_t;

  localparam int PAY_W = $bits(pay_t);

  occ_e state_q, state_d;
  logic rdy_en_q;
  logic main_valid, skid_valid;
  pay_t in_pay, main_src, main_pay, skid_pay;
  logic ld_main, sel_skid, ld_skid, clr_main, clr_skid;
  logic in_ready, fire_in, fire_out, taken, redirect;

  // in_ready is held low through reset and the first edge after it
  assign in_ready = rdy_en_q & ~skid_valid;
  assign fire_in  = bus.in_valid & in_ready;
  assign fire_out = main_valid & bus.out_ready;

  assign taken    = main_valid & ((main_pay.ctrl[CTRL_BRANCH] & main_pay.zero) |
                                  main_pay.ctrl[CTRL_JUMP]);
  assign redirect = taken & bus.out_ready;

  always_comb begin
    in_pay      = '0;
    in_pay.ctrl = bus.in_valid ? {bus.in_wb_regwrite, bus.in_wb_memtoreg, bus.in_m_branch,
                                  bus.in_m_memread, bus.in_m_memwrite, bus.in_jump}
                               : '0;
    in_pay.zero = bus.in_zero;
    in_pay.alu  = bus.in_alu_result;
    in_pay.sd   = bus.in_store_data;
    in_pay.bt   = bus.in_br_target;
    in_pay.jt   = bus.in_jmp_target;
    in_pay.dst  = bus.in_dest_reg;
  end

  // FSM: state register
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q  <= OCC_EMPTY;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // FSM: next state; a redirect or flush squashes everything younger
  always_comb begin
    state_d = state_q;
    if (flush || redirect) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (fire_in) state_d = OCC_ONE;
        OCC_ONE: begin
          if (fire_in && !fire_out)      state_d = OCC_TWO;
          else if (!fire_in && fire_out) state_d = OCC_EMPTY;
        end
        OCC_TWO:   if (fire_out) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // FSM: slot controls
  always_comb begin
    ld_main  = 1'b0;
    sel_skid = 1'b0;
    ld_skid  = 1'b0;
    clr_main = 1'b0;
    clr_skid = 1'b0;
    if (flush || redirect) begin
      clr_main = 1'b1;
      clr_skid = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: ld_main = fire_in;
        OCC_ONE: begin
          if (fire_in && fire_out) ld_main  = 1'b1;
          else if (fire_in)        ld_skid  = 1'b1;
          else if (fire_out)       clr_main = 1'b1;
        end
        OCC_TWO: begin
          if (fire_out) begin
            ld_main  = 1'b1;
            sel_skid = 1'b1;
            clr_skid = 1'b1;
          end
        end
        default: begin
          clr_main = 1'b1;
          clr_skid = 1'b1;
        end
      endcase
    end
  end

  assign main_src = sel_skid ? skid_pay : in_pay;

  ex_mem_slot #(.W(PAY_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ld_main),
    .clr_i   (clr_main),
    .d_i     (main_src),
    .valid_o (main_valid),
    .q_o     (main_pay)
  );

  ex_mem_slot #(.W(PAY_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ld_skid),
    .clr_i   (clr_skid),
    .d_i     (in_pay),
    .valid_o (skid_valid),
    .q_o     (skid_pay)
  );

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = main_valid;
  assign bus.out_wb_regwrite = main_valid & main_pay.ctrl[CTRL_REGWRITE];
  assign bus.out_wb_memtoreg = main_valid & main_pay.ctrl[CTRL_MEMTOREG];
  assign bus.out_m_memread   = main_valid & main_pay.ctrl[CTRL_MEMREAD];
  assign bus.out_m_memwrite  = main_valid & main_pay.ctrl[CTRL_MEMWRITE];
  assign bus.out_alu_result  = main_pay.alu;
  assign bus.out_store_data  = main_pay.sd;
  assign bus.out_dest_reg    = main_pay.dst;
  assign bus.pc_redirect     = redirect;
  assign bus.pc_target       = main_pay.ctrl[CTRL_JUMP] ? main_pay.jt : main_pay.bt;
  assign bus.flush_upstream  = redirect;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: an in-order queue of accepted
// instructions (capacity 2) predicts every output each cycle.
module tb_ex_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_W(DW), .REG_W(RW)) bus();

  ex_mem_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    bit          rw, mtr, br, mr, mw, jmp, zero;
    bit [DW-1:0] alu, sd, bt, jt;
    bit [RW-1:0] dst;
  } item_t;

  item_t exp_q[$];
  item_t h, nx;
  bit    ready_m, known, after_rst, ev, taken, redir;
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus: one instruction slot per clock; c = {rw,mtr,br,mr,mw,jmp}
  task automatic put(input bit v, input bit ordy, input bit [5:0] c, input bit z,
                     input bit [31:0] alu, input bit [31:0] bt, input bit [31:0] jt);
    @(posedge clk);
    flush              = 1'b0;
    bus.in_valid       = v;
    bus.out_ready      = ordy;
    {bus.in_wb_regwrite, bus.in_wb_memtoreg, bus.in_m_branch,
     bus.in_m_memread, bus.in_m_memwrite, bus.in_jump} = c;
    bus.in_zero        = z;
    bus.in_alu_result  = alu;
    bus.in_store_data  = $urandom;
    bus.in_br_target   = bt;
    bus.in_jmp_target  = jt;
    bus.in_dest_reg    = RW'($urandom);
  endtask

  task automatic idle(input bit ordy);
    put(1'b0, ordy, 6'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic alu_op(input bit ordy, input bit [31:0] alu);
    put(1'b1, ordy, {1'b1, 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0},
        1'($urandom), alu, $urandom, $urandom);
  endtask

  // Monitor + reference model, sampled between drive (posedge) and commit (negedge)
  initial begin
    forever begin
      @(posedge clk);
      #2;
      redir = 1'b0;
      if (known) begin
        ev = exp_q.size() > 0;
        if (ev) h = exp_q[0];
        else    h = '{default: 0};
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        chk("in_ready", 32'(bus.in_ready), 32'(ready_m));
        chk("ctrl_out", 32'({bus.out_wb_regwrite, bus.out_wb_memtoreg, bus.out_m_memread, bus.out_m_memwrite}),
            ev ? 32'({h.rw, h.mtr, h.mr, h.mw}) : 32'd0);
        if (ev) begin
          chk("alu_result", bus.out_alu_result, h.alu);
          chk("store_data", bus.out_store_data, h.sd);
          chk("dest_reg", 32'(bus.out_dest_reg), 32'(h.dst));
        end
        taken = ev && ((h.br && h.zero) || h.jmp);
        redir = taken && bus.out_ready;
        chk("pc_redirect", 32'(bus.pc_redirect), 32'(redir));
        chk("flush_upstream", 32'(bus.flush_upstream), 32'(redir));
        if (redir) chk("pc_target", bus.pc_target, h.jmp ? h.jt : h.bt);
        if (after_rst) begin
          chk("rst_alu_result", bus.out_alu_result, 32'd0);
          chk("rst_pc_target", bus.pc_target, 32'd0);
        end
      end
      if (!rst_n) begin
        exp_q.delete();
        ready_m   = 1'b0;
        known     = 1'b1;
        after_rst = 1'b1;
      end else begin
        after_rst = 1'b0;
        if (redir || flush) begin
          exp_q.delete();
        end else begin
          if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
          if (bus.in_valid && ready_m) begin
            nx.rw  = bus.in_wb_regwrite;
            nx.mtr = bus.in_wb_memtoreg;
            nx.br  = bus.in_m_branch;
            nx.mr  = bus.in_m_memread;
            nx.mw  = bus.in_m_memwrite;
            nx.jmp = bus.in_jump;
            nx.zero = bus.in_zero;
            nx.alu = bus.in_alu_result;
            nx.sd  = bus.in_store_data;
            nx.bt  = bus.in_br_target;
            nx.jt  = bus.in_jmp_target;
            nx.dst = bus.in_dest_reg;
            exp_q.push_back(nx);
          end
        end
        ready_m = exp_q.size() < 2;
      end
    end
  end

  initial begin
    #500000;
    if (!done) begin
      $display("FAIL watchdog: stimulus did not complete");
      $fatal(1);
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    {bus.in_wb_regwrite, bus.in_wb_memtoreg, bus.in_m_branch,
     bus.in_m_memread, bus.in_m_memwrite, bus.in_jump, bus.in_zero} = '0;
    bus.in_alu_result = '0;
    bus.in_store_data = '0;
    bus.in_br_target  = '0;
    bus.in_jmp_target = '0;
    bus.in_dest_reg   = '0;

    // reset held two edges with in_valid high
    rst_n = 1'b0;
    alu_op(1'b1, 32'h99);
    alu_op(1'b1, 32'h98);
    idle(1'b1);
    rst_n = 1'b1;
    idle(1'b1);

    // streaming
    for (int i = 0; i < 4; i++) alu_op(1'b1, 32'h10 + i);
    idle(1'b1);
    idle(1'b1);

    // stall: A main, B skid, C held until the skid drains
    alu_op(1'b0, 32'hA0);
    alu_op(1'b0, 32'hB0);
    alu_op(1'b0, 32'hC0);
    alu_op(1'b1, 32'hC0);
    alu_op(1'b1, 32'hC0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // taken branch with a younger op in the skid
    put(1'b1, 1'b0, 6'b001000, 1'b1, 32'hB0, 32'h0000_0040, 32'h1234_5678);
    alu_op(1'b0, 32'hB1);
    idle(1'b1);
    idle(1'b1);
    // taken branch with a same-cycle younger input
    put(1'b1, 1'b0, 6'b001000, 1'b1, 32'hB2, 32'h0000_0080, 32'h1234_5678);
    alu_op(1'b1, 32'hB3);
    idle(1'b1);

    // jump + branch together, then not-taken branch
    put(1'b1, 1'b1, 6'b001001, 1'b1, 32'hC1, 32'h0000_0040, 32'h0040_0000);
    put(1'b1, 1'b1, 6'b001000, 1'b0, 32'hC2, 32'h0000_0100, 32'h0040_0000);
    alu_op(1'b1, 32'hC3);
    idle(1'b1);

    // flush in TWO with input presented, then in ONE with same-edge fire_in
    alu_op(1'b0, 32'hD0);
    alu_op(1'b0, 32'hD1);
    alu_op(1'b0, 32'hD2);
    flush = 1'b1;
    alu_op(1'b1, 32'hD3);
    idle(1'b0);
    alu_op(1'b0, 32'hD4);
    flush = 1'b1;
    idle(1'b1);

    // reset in the middle of a stall
    alu_op(1'b0, 32'hE0);
    alu_op(1'b0, 32'hE1);
    idle(1'b0);
    rst_n = 1'b0;
    idle(1'b1);
    rst_n = 1'b1;
    alu_op(1'b1, 32'hE2);
    idle(1'b1);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      put(($urandom % 4) != 0, ($urandom % 3) != 0,
          {1'($urandom), 1'($urandom), ($urandom % 6) == 0, 1'($urandom), 1'($urandom),
           ($urandom % 10) == 0},
          1'($urandom), $urandom, $urandom, $urandom);
      if (($urandom % 40) == 0) flush = 1'b1;
      rst_n = (($urandom % 100) != 0);
    end
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    @(posedge clk);
    #3;
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
